// File: rtl/db_controller.sv
// Debug command controller: decodes serial_driver commands into MCU pause/reset, memory and register-file accesses.
// Optional feature: define DB_RF_ACCESS_EN to enable RF_RD / RF_WR register-file access.
module db_controller #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  input  logic        out_valid,
  output logic        busy,
  output logic [31:0] d_rd,
  output logic        error,
  output logic        mcu_pause,
  input  logic        mcu_paused,
  output logic        mcu_rst,
  output logic        mem_rd,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rf_rd,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  input  logic [31:0] rf_rdata
);

  localparam logic [3:0] C_PAUSE     = 4'h1;
  localparam logic [3:0] C_RESUME    = 4'h2;
  localparam logic [3:0] C_STATUS    = 4'h3;
  localparam logic [3:0] C_MCU_RESET = 4'h4;
  localparam logic [3:0] C_RF_RD     = 4'h5;
  localparam logic [3:0] C_RF_WR     = 4'h6;
  localparam logic [3:0] C_MEM_RD    = 4'hA;
  localparam logic [3:0] C_MEM_WR    = 4'hC;

  localparam int CW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);
  localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;

`ifdef DB_RF_ACCESS_EN
  localparam logic RF_EN = 1'b1;
`else
  localparam logic RF_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PAUSE = 3'd1,
    S_MEM   = 3'd2,
    S_RF    = 3'd3,
    S_RST   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cmd;
  logic [31:0]     r_addr;
  logic [31:0]     r_din;
  logic [31:0]     r_reply;
  logic            r_err;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_tmo;
  logic [3:0]      w_cmd_cur;
  logic            w_legal;
  logic            w_rf_reject;
  logic [31:0]     w_final;
  logic            r_busy;
  logic            r_mcu_pause;
  logic            r_mcu_rst;
  logic            r_mem_rd;
  logic            r_mem_we;
  logic [31:0]     r_d_rd;
  logic            r_error;
  logic            w_busy_nx;
  logic            w_mcu_rst_nx;
  logic            w_mem_rd_nx;
  logic            w_mem_we_nx;

  // Outside S_IDLE the latched command drives the strobes, in S_IDLE the incoming one does.
  assign w_cmd_cur   = (r_state == S_IDLE) ? cmd : r_cmd;
  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_tmo       = (w_cnt_inc == TMO);
  assign w_rf_reject = ((cmd == C_RF_RD) || (cmd == C_RF_WR)) && !mcu_paused;

  always_comb begin
    w_legal = 1'b0;
    case (cmd)
      C_PAUSE, C_RESUME, C_STATUS, C_MCU_RESET, C_MEM_RD, C_MEM_WR: w_legal = 1'b1;
      C_RF_RD, C_RF_WR: w_legal = RF_EN;
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!out_valid) begin
          w_next = S_IDLE;
        end else if (!w_legal) begin
          w_next = S_DONE;
        end else begin
          case (cmd)
            C_PAUSE:            w_next = S_PAUSE;
            C_MCU_RESET:        w_next = S_RST;
            C_MEM_RD, C_MEM_WR: w_next = S_MEM;
            C_RF_RD, C_RF_WR:   w_next = w_rf_reject ? S_DONE : S_RF;
            default:            w_next = S_DONE;
          endcase
        end
      end
      S_PAUSE: w_next = mcu_paused ? S_DONE : S_PAUSE;
      // An ack on the timeout cycle still counts as success.
      S_MEM:   w_next = (mem_ack || w_tmo) ? S_DONE : S_MEM;
      S_RF:    w_next = S_DONE;
      S_RST:   w_next = (r_cnt == CW'(1)) ? S_DONE : S_RST;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nx    = (w_next != S_IDLE);
    w_mcu_rst_nx = (w_next == S_RST);
    w_mem_rd_nx  = (w_next == S_MEM) && (w_cmd_cur == C_MEM_RD);
    w_mem_we_nx  = (w_next == S_MEM) && (w_cmd_cur == C_MEM_WR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_mcu_rst <= 1'b0;
      r_mem_rd  <= 1'b0;
      r_mem_we  <= 1'b0;
    end else begin
      r_busy    <= w_busy_nx;
      r_mcu_rst <= w_mcu_rst_nx;
      r_mem_rd  <= w_mem_rd_nx;
      r_mem_we  <= w_mem_we_nx;
    end
  end

  always_comb begin
    w_final = r_reply;
    if (!r_err && (r_cmd == C_STATUS)) begin
      w_final = {30'b0, r_mcu_pause, mcu_paused};
`ifdef DB_RF_ACCESS_EN
    end else if (!r_err && (r_cmd == C_RF_RD)) begin
      // rf_rdata is valid in S_DONE, one cycle after the rf_rd strobe.
      w_final = rf_rdata;
`endif
    end else begin
      w_final = r_reply;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd       <= 4'h0;
      r_addr      <= 32'h0;
      r_din       <= 32'h0;
      r_reply     <= 32'h0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_mcu_pause <= 1'b0;
      r_d_rd      <= 32'h0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (out_valid) begin
            r_cmd   <= cmd;
            r_addr  <= addr;
            r_din   <= d_in;
            r_cnt   <= '0;
            r_error <= 1'b0;
            if (!w_legal || w_rf_reject) begin
              r_err   <= 1'b1;
              r_reply <= ERR_WORD;
            end else begin
              r_err   <= 1'b0;
              r_reply <= ((cmd == C_MEM_WR) || (cmd == C_RF_WR)) ? d_in : 32'h0;
            end
            case (cmd)
              C_PAUSE:               r_mcu_pause <= 1'b1;
              C_RESUME, C_MCU_RESET: r_mcu_pause <= 1'b0;
              default:               r_mcu_pause <= r_mcu_pause;
            endcase
          end
        end
        S_MEM: begin
          r_cnt <= w_cnt_inc;
          if (mem_ack) begin
            if (r_cmd == C_MEM_RD) begin
              r_reply <= mem_rdata;
            end
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_reply <= ERR_WORD;
          end
        end
        S_RST: r_cnt <= w_cnt_inc;
        S_DONE: begin
          r_d_rd  <= w_final;
          r_error <= r_err;
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign busy      = r_busy;
  assign d_rd      = r_d_rd;
  assign error     = r_error;
  assign mcu_pause = r_mcu_pause;
  assign mcu_rst   = r_mcu_rst;
  assign mem_rd    = r_mem_rd;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr & 32'hFFFF_FFFC;
  assign mem_wdata = r_din;

`ifdef DB_RF_ACCESS_EN
  logic r_rf_rd;
  logic r_rf_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rf_rd <= 1'b0;
      r_rf_we <= 1'b0;
    end else begin
      r_rf_rd <= (w_next == S_RF) && (w_cmd_cur == C_RF_RD);
      r_rf_we <= (w_next == S_RF) && (w_cmd_cur == C_RF_WR);
    end
  end

  assign rf_rd    = r_rf_rd;
  assign rf_we    = r_rf_we;
  assign rf_addr  = r_addr[4:0];
  assign rf_wdata = r_din;
`else
  assign rf_rd    = 1'b0;
  assign rf_we    = 1'b0;
  assign rf_addr  = 5'b0;
  assign rf_wdata = 32'b0;
`endif

endmodule

// File: tb/tb_db_controller.sv
// Self-checking bench for db_controller: scoreboard of expected replies, one task per scenario.
module tb_db_controller;

  localparam logic [3:0] C_PAUSE     = 4'h1;
  localparam logic [3:0] C_RESUME    = 4'h2;
  localparam logic [3:0] C_STATUS    = 4'h3;
  localparam logic [3:0] C_MCU_RESET = 4'h4;
  localparam logic [3:0] C_RF_RD     = 4'h5;
  localparam logic [3:0] C_RF_WR     = 4'h6;
  localparam logic [3:0] C_MEM_RD    = 4'hA;
  localparam logic [3:0] C_MEM_WR    = 4'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cmd = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] d_in = 32'h0;
  logic        out_valid = 1'b0;
  logic        busy;
  logic [31:0] d_rd;
  logic        error;
  logic        mcu_pause;
  logic        mcu_paused = 1'b0;
  logic        mcu_rst;
  logic        mem_rd;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        rf_rd;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata = 32'h0;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_busy, m_req, m_rstc, m_rf;
  logic [31:0] m_addr, m_wdata;
  logic [4:0]  m_rfaddr;
  logic [31:0] rf_val = 32'h0;

  db_controller #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .addr(addr), .d_in(d_in), .out_valid(out_valid),
    .busy(busy), .d_rd(d_rd), .error(error), .mcu_pause(mcu_pause), .mcu_paused(mcu_paused),
    .mcu_rst(mcu_rst), .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rf_rd(rf_rd),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one command, act as MCU/memory/RF responder while busy, then score the reply.
  task automatic run_cmd(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d,
                         input int ack_at, input int paused_at, input bit inject);
    logic prev_rf;
    exp_t exp;
    cmd = c; addr = a; d_in = d; out_valid = 1'b1;
    tick;
    out_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL accept_%h: busy=%b error=%b, required busy=1 error=0", c, busy, error);
    end
    m_busy = 0; m_req = 0; m_rstc = 0; m_rf = 0; prev_rf = 1'b0;
    while (busy === 1'b1 && m_busy < 200) begin
      m_busy++;
      if (mem_rd | mem_we) begin m_req++; m_addr = mem_addr; m_wdata = mem_wdata; end
      if (mcu_rst) m_rstc++;
      if (rf_rd | rf_we) begin m_rf++; m_rfaddr = rf_addr; end
      mem_ack = (ack_at != 0) && (mem_rd | mem_we) && (m_req == ack_at);
      if (paused_at != 0 && m_busy == paused_at) mcu_paused = 1'b1;
      rf_rdata = prev_rf ? rf_val : 32'h0BAD_0BAD;
      prev_rf = rf_rd;
      if (inject && m_busy == 1) begin out_valid = 1'b1; cmd = C_PAUSE; end
      tick;
      out_valid = 1'b0;
    end
    mem_ack = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL done_%h: busy still %b after %0d cycles, required 0", c, busy, m_busy);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_%h: queue empty, required an expected entry", c);
    end else begin
      exp = sb_q.pop_front();
      if (d_rd !== exp.d || error !== exp.e) begin
        errors++;
        $display("FAIL reply_%h: d_rd=%h error=%b, required d_rd=%h error=%b", c, d_rd, error, exp.d, exp.e);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic test_reset;
    tick; tick;
    checks++;
    if ({busy, error, mcu_pause, mcu_rst, mem_rd, mem_we, rf_rd, rf_we} !== 8'b0 || d_rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: outputs=%b d_rd=%h, required all 0", {busy, error, mcu_pause, mcu_rst, mem_rd, mem_we, rf_rd, rf_we}, d_rd);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_status;
    sb_q.push_back('{d: 32'h0, e: 1'b0});
    run_cmd(C_STATUS, 32'h0, 32'h0, 0, 0, 1'b0);
    chk("status_busy_len", m_busy, 1);
  endtask

  task automatic test_rf_unpaused;
    mcu_paused = 1'b0;
    sb_q.push_back('{d: 32'hFFFF_FFFF, e: 1'b1});
    run_cmd(C_RF_RD, 32'h5, 32'h0, 0, 0, 1'b0);
    chk("rf_unpaused_no_strobe", m_rf, 0);
    chk("rf_unpaused_busy_len", m_busy, 1);
  endtask

  task automatic test_pause;
    sb_q.push_back('{d: 32'h0, e: 1'b0});
    run_cmd(C_PAUSE, 32'h0, 32'h0, 0, 5, 1'b0);
    chk("pause_busy_len", m_busy, 6);
    chk("pause_mcu_pause", {31'b0, mcu_pause}, 1);
    sb_q.push_back('{d: 32'h3, e: 1'b0});
    run_cmd(C_STATUS, 32'h0, 32'h0, 0, 0, 1'b0);
  endtask

  task automatic test_rf_paused;
`ifdef DB_RF_ACCESS_EN
    rf_val = 32'hCAFE_F00D;
    sb_q.push_back('{d: 32'hCAFE_F00D, e: 1'b0});
    run_cmd(C_RF_RD, 32'h5, 32'h0, 0, 0, 1'b0);
    chk("rf_rd_strobes", m_rf, 1);
    chk("rf_rd_addr", {27'b0, m_rfaddr}, 32'h5);
    chk("rf_rd_busy_len", m_busy, 2);
    sb_q.push_back('{d: 32'h0000_55AA, e: 1'b0});
    run_cmd(C_RF_WR, 32'h20, 32'h0000_55AA, 0, 0, 1'b0);
    chk("rf_wr_strobes", m_rf, 1);
    chk("rf_wr_addr0", {27'b0, m_rfaddr}, 32'h0);
`else
    sb_q.push_back('{d: 32'hFFFF_FFFF, e: 1'b1});
    run_cmd(C_RF_RD, 32'h5, 32'h0, 0, 0, 1'b0);
    chk("rf_disabled_no_strobe", m_rf, 0);
    sb_q.push_back('{d: 32'hFFFF_FFFF, e: 1'b1});
    run_cmd(C_RF_WR, 32'h0, 32'h0000_55AA, 0, 0, 1'b0);
    chk("rf_wr_disabled_busy_len", m_busy, 1);
`endif
  endtask

  task automatic test_resume;
    sb_q.push_back('{d: 32'h0, e: 1'b0});
    run_cmd(C_RESUME, 32'h0, 32'h0, 0, 0, 1'b0);
    chk("resume_busy_len", m_busy, 1);
    chk("resume_mcu_pause", {31'b0, mcu_pause}, 0);
    mcu_paused = 1'b0;
  endtask

  task automatic test_mem;
    sb_q.push_back('{d: 32'h1234_5678, e: 1'b0});
    run_cmd(C_MEM_WR, 32'h0000_0103, 32'h1234_5678, 3, 0, 1'b0);
    chk("memwr_we_cycles", m_req, 3);
    chk("memwr_addr", m_addr, 32'h0000_0100);
    chk("memwr_wdata", m_wdata, 32'h1234_5678);
    chk("memwr_busy_len", m_busy, 4);
    mem_rdata = 32'hA5A5_0001;
    sb_q.push_back('{d: 32'hA5A5_0001, e: 1'b0});
    run_cmd(C_MEM_RD, 32'h0000_0206, 32'h0, 1, 0, 1'b0);
    chk("memrd_rd_cycles", m_req, 1);
    chk("memrd_addr", m_addr, 32'h0000_0204);
  endtask

  task automatic test_mem_timeout;
    sb_q.push_back('{d: 32'hFFFF_FFFF, e: 1'b1});
    run_cmd(C_MEM_RD, 32'h0000_0300, 32'h0, 0, 0, 1'b0);
    chk("timeout_req_cycles", m_req, 16);
    mem_rdata = 32'h7777_1616;
    sb_q.push_back('{d: 32'h7777_1616, e: 1'b0});
    run_cmd(C_MEM_RD, 32'h0000_0304, 32'h0, 16, 0, 1'b0);
    chk("ack_at_timeout_req_cycles", m_req, 16);
    chk("ack_at_timeout_busy_len", m_busy, 17);
  endtask

  task automatic test_mcu_reset;
    sb_q.push_back('{d: 32'h0, e: 1'b0});
    run_cmd(C_PAUSE, 32'h0, 32'h0, 0, 1, 1'b0);
    chk("pause_fast_busy_len", m_busy, 2);
    mcu_paused = 1'b0;
    sb_q.push_back('{d: 32'h0, e: 1'b0});
    run_cmd(C_MCU_RESET, 32'h0, 32'h0, 0, 0, 1'b0);
    chk("mcu_rst_cycles", m_rstc, 2);
    chk("mcu_reset_busy_len", m_busy, 3);
    chk("mcu_reset_clears_pause", {31'b0, mcu_pause}, 0);
  endtask

  task automatic test_illegal;
    sb_q.push_back('{d: 32'hFFFF_FFFF, e: 1'b1});
    run_cmd(4'h7, 32'h0, 32'h0, 0, 0, 1'b1);
    chk("illegal_busy_len", m_busy, 1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || mcu_pause !== 1'b0 || d_rd !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL ignored_strobe: busy=%b mcu_pause=%b d_rd=%h, required 0 0 ffffffff", busy, mcu_pause, d_rd);
      end
      tick;
    end
  endtask

  task automatic test_reset_mid_cmd;
    cmd = C_MEM_RD; addr = 32'h0000_0040; out_valid = 1'b1;
    tick;
    out_valid = 1'b0;
    chk("midcmd_error_cleared", {31'b0, error}, 0);
    tick;
    chk("midcmd_mem_rd_active", {31'b0, mem_rd}, 1);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_rd !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: mem_rd=%b busy=%b, required 0 0", mem_rd, busy);
    end
    tick; tick;
    reset = 1'b0;
    chk("after_reset_d_rd", d_rd, 32'h0);
    chk("after_reset_error", {31'b0, error}, 0);
    tick;
    sb_q.push_back('{d: 32'h0, e: 1'b0});
    run_cmd(C_STATUS, 32'h0, 32'h0, 0, 0, 1'b0);
    mem_rdata = 32'h0F0F_3C3C;
    sb_q.push_back('{d: 32'h0F0F_3C3C, e: 1'b0});
    run_cmd(C_MEM_RD, 32'h0000_0040, 32'h0, 2, 0, 1'b0);
    chk("post_reset_memrd_cycles", m_req, 2);
  endtask

  initial begin
    test_reset;
    test_status;
    test_rf_unpaused;
    test_pause;
    test_rf_paused;
    test_resume;
    test_mem;
    test_mem_timeout;
    test_mcu_reset;
    test_illegal;
    test_reset_mid_cmd;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/db_controller.md
DB_CONTROLLER -- requirements
Module: db_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning the number of cycles to wait for mem_ack before aborting with error.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port cmd, input, 4 bits: command code from serial_driver.
REQ-005 SHALL have port addr, input, 32 bits: address operand from serial_driver.
REQ-006 SHALL have port d_in, input, 32 bits: data operand from serial_driver.
REQ-007 SHALL have port out_valid, input, 1 bit: single-cycle command strobe.
REQ-008 SHALL have port busy, output, 1 bit: command in progress; connects to the driver's ctrlr_busy.
REQ-009 SHALL have port d_rd, output, 32 bits: reply word, valid whenever busy is 0.
REQ-010 SHALL have port error, output, 1 bit: set when the last command failed.
REQ-011 SHALL have port mcu_pause, output, 1 bit: pause request to the MCU.
REQ-012 SHALL have port mcu_paused, input, 1 bit: MCU acknowledges it is halted.
REQ-013 SHALL have port mcu_rst, output, 1 bit: MCU reset pulse.
REQ-014 SHALL have port mem_rd / mem_we, output, 1 bit each: memory read/write request.
REQ-015 SHALL have port mem_addr / mem_wdata, output, 32 bits each: memory address and write data.
REQ-016 SHALL have port mem_rdata, input, 32 bits, and port mem_ack, input, 1 bit: read data and access completion.
REQ-017 SHALL have port rf_rd / rf_we, output, 1 bit each; rf_addr, output, 5 bits; rf_wdata, output, 32 bits; rf_rdata, input, 32 bits: register-file access, with read data valid 1 cycle after rf_rd.

Function
REQ-018 SHALL decode the following commands: 0x1 PAUSE, 0x2 RESUME, 0x3 STATUS, 0x4 MCU_RESET, 0x5 RF_RD, 0x6 RF_WR, 0xA MEM_RD_WORD, 0xC MEM_WR_WORD; every other code is illegal.
REQ-019 SHALL use the states S_IDLE, S_PAUSE, S_MEM, S_RF, S_RST and S_DONE, held in a registered FSM.
REQ-020 SHALL, in S_IDLE with out_valid=1, latch cmd, addr and d_in, and drive busy=1 from the next cycle.
REQ-021 SHALL ignore out_valid when busy=1: no latch, no state change.
REQ-022 SHALL hold busy high for at least 1 cycle per accepted command.
REQ-023 SHALL update d_rd and error in the same cycle that busy falls, and hold them until the next accepted command.
REQ-024 SHALL handle PAUSE as: set mcu_pause=1, go to S_PAUSE, wait for mcu_paused=1, then go to S_DONE with d_rd=0.
REQ-025 SHALL handle RESUME as: set mcu_pause=0, d_rd=0, go directly to S_DONE.
REQ-026 SHALL handle STATUS as: d_rd={30'b0, mcu_pause, mcu_paused}, with a 1-cycle busy.
REQ-027 SHALL handle MCU_RESET as: assert mcu_rst for exactly 2 cycles (S_RST), clear mcu_pause, d_rd=0.
REQ-028 SHALL handle MEM_RD_WORD / MEM_WR_WORD as follows:
- assert mem_rd or mem_we, with mem_addr={addr[31:2], 2'b00} and mem_wdata=d_in;
- hold the request until mem_ack=1;
- on a read, capture mem_rdata into d_rd; on a write, set d_rd=d_in.
REQ-029 SHALL, in S_MEM, count cycles from 0; when the count reaches MEM_TIMEOUT without mem_ack, drop the request, set error=1 and d_rd=32'hFFFF_FFFF.
REQ-030 SHALL allow memory commands regardless of pause state, so that programming mode writes stream unpaused.
REQ-031 SHALL handle RF_RD / RF_WR only when mcu_paused=1, using rf_addr=addr[4:0]; RF_RD returns rf_rdata, RF_WR returns d_in.
REQ-032 SHALL reject RF_RD / RF_WR with mcu_paused=0 using error=1 and d_rd=32'hFFFF_FFFF, without asserting rf_rd or rf_we.
REQ-033 SHALL handle writes to rf_addr 0 by asserting rf_we normally; the register file discards the data, and the reply is d_in.
REQ-034 SHALL respond to an illegal command with error=1, d_rd=32'hFFFF_FFFF and a 1-cycle busy.
REQ-035 SHALL clear error when the next command is accepted.
REQ-036 SHALL, if mem_ack arrives on the same cycle the timeout count reaches MEM_TIMEOUT, treat the access as a success.
REQ-037 SHALL never assert mem_rd, mem_we, rf_rd or rf_we outside S_MEM or S_RF.
REQ-038 SHALL return from S_DONE to S_IDLE after 1 cycle.

Reset
REQ-039 SHALL, while reset=1, drive state to S_IDLE, busy=0, error=0, d_rd=0, mcu_pause=0, mcu_rst=0, all mem_* and rf_* strobes to 0, and the timeout counter to 0.
REQ-040 SHALL, on reset mid-command, abandon the access immediately, with no reply and no pending strobe.

Configuration
REQ-041 SHALL use the macro DB_RF_ACCESS_EN to gate register-file access.
REQ-042 SHALL, with DB_RF_ACCESS_EN defined, implement RF_RD / RF_WR as specified above.
REQ-043 SHALL, without DB_RF_ACCESS_EN, treat 0x5 and 0x6 as illegal commands, tie rf_rd, rf_we, rf_addr and rf_wdata to 0, and leave rf_rdata unused.

Verification
REQ-044 SHALL cover: PAUSE with mcu_paused raised 5 cycles later -> mcu_pause=1, busy high for 6 cycles, d_rd=0, error=0.
REQ-045 SHALL cover: MEM_WR_WORD addr=0x0000_0103, d_in=0x1234_5678, mem_ack after 3 cycles -> mem_addr=0x0000_0100, mem_we held 3 cycles, d_rd=0x1234_5678.
REQ-046 SHALL cover: MEM_RD_WORD with no mem_ack and MEM_TIMEOUT=16 -> request dropped after 16 cycles, error=1, d_rd=0xFFFF_FFFF.
REQ-047 SHALL cover: RF_RD addr=5 while unpaused -> error=1, rf_rd never asserted; after PAUSE, RF_RD with rf_rdata=0xCAFE_F00D -> d_rd=0xCAFE_F00D.
REQ-048 SHALL cover: cmd=0x7 -> error=1, d_rd=0xFFFF_FFFF, busy high for 1 cycle; an out_valid pulse during busy is ignored.
REQ-049 SHALL cover: reset asserted mid-MEM_RD -> mem_rd=0 and busy=0 asynchronously, and the next command executes normally.
